// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, data-memory responder FSM states and sizing.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam int DMEM_BYTES_DEFAULT = 4096;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } dmem_state_e;

endpackage

// File: rtl/dmem_responder_if.sv
// Memory-stage request/response bundle between the pipeline (master) and the data-memory responder (slave).
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        mem_r;
  logic        mem_w;
  logic [63:0] mem_add;
  logic [63:0] mem_data;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] valM;
  logic        dmem_error;

  modport master (
    output req_valid, mem_r, mem_w, mem_add, mem_data, resp_ready,
    input  req_ready, resp_valid, valM, dmem_error
  );

  modport slave (
    input  req_valid, mem_r, mem_w, mem_add, mem_data, resp_ready,
    output req_ready, resp_valid, valM, dmem_error
  );
endinterface

// File: rtl/dmem_array.sv
// Byte-addressed little-endian storage with an 8-byte port: combinational read, synchronous write.
module dmem_array #(
  parameter int MEM_BYTES = 4096,
  localparam int AW = $clog2(MEM_BYTES)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [63:0]   wdata,
  output logic [63:0]   rdata
);

  logic [7:0] mem [MEM_BYTES];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int k = 0; k < 8; k++) begin
        mem[addr + AW'(k)] <= wdata[8*k +: 8];
      end
    end
  end

  always_comb begin
    rdata = '0;
    for (int k = 0; k < 8; k++) begin
      rdata[8*k +: 8] = mem[addr + AW'(k)];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Y86 data-memory responder: accept -> one access cycle -> response held until resp_ready (2 edges min).
// Optional DMEM_ALIGN_CHECK_EN faults any access whose address is not 8-byte aligned.
module dmem_responder
  import y86_pkg::*;
#(
  parameter int MEM_BYTES = DMEM_BYTES_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  dmem_responder_if.slave   bus
);

  localparam int          AW      = $clog2(MEM_BYTES);
  localparam logic [63:0] MAX_ADD = 64'(MEM_BYTES - 8);

  dmem_state_e state_q, state_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic [63:0] add_q, add_d;
  logic [63:0] wdat_q, wdat_d;
  logic [63:0] valm_q, valm_d;
  logic        err_q, err_d;

  logic        misaligned;
  logic        acc_err;
  logic        arr_we;
  logic [63:0] arr_rdata;

`ifdef DMEM_ALIGN_CHECK_EN
  assign misaligned = |add_q[2:0];
`else
  assign misaligned = 1'b0;
`endif

  // Opcode must be exactly one of read/write; full 64-bit compare catches upper address bits.
  assign acc_err = (rd_q == wr_q) || (add_q > MAX_ADD) || misaligned;
  // A reset landing on the ACCESS edge must not commit the write.
  assign arr_we  = (state_q == ACCESS) && wr_q && !acc_err && !rst;

  dmem_array #(.MEM_BYTES(MEM_BYTES)) u_array (
    .clk   (clk),
    .we    (arr_we),
    .addr  (add_q[AW-1:0]),
    .wdata (wdat_q),
    .rdata (arr_rdata)
  );

  always_comb begin
    state_d = state_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    add_d   = add_q;
    wdat_d  = wdat_q;
    valm_d  = valm_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          rd_d    = bus.mem_r;
          wr_d    = bus.mem_w;
          add_d   = bus.mem_add;
          wdat_d  = bus.mem_data;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        err_d   = acc_err;
        valm_d  = (rd_q && !acc_err) ? arr_rdata : 64'd0;
        state_d = RESP;
      end
      RESP: begin
        // Response registers return to zero as we leave so outputs read 0 outside RESP.
        if (bus.resp_ready) begin
          valm_d  = 64'd0;
          err_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        valm_d  = 64'd0;
        err_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      add_q   <= 64'd0;
      wdat_q  <= 64'd0;
      valm_q  <= 64'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      add_q   <= add_d;
      wdat_q  <= wdat_d;
      valm_q  <= valm_d;
      err_q   <= err_d;
    end
  end

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = (state_q == RESP);
  assign bus.valM       = valm_q;
  assign bus.dmem_error = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed plus randomized checks of dmem_responder against a byte-array reference model.
module tb_dmem_responder;

  localparam int MEM_BYTES = 4096;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  bit [7:0] mdl [MEM_BYTES];
  bit       kn  [MEM_BYTES];

  dmem_responder_if bus ();

  dmem_responder #(.MEM_BYTES(MEM_BYTES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit pred_err(input logic r, input logic w, input logic [63:0] add);
    bit e;
    e = (r == w) || (add > 64'(MEM_BYTES - 8));
`ifdef DMEM_ALIGN_CHECK_EN
    if (add[2:0] != 3'd0) e = 1'b1;
`endif
    return e;
  endfunction

  // One complete transaction, entered and left on a negedge with the DUT idle.
  task automatic access(input logic r, input logic w, input logic [63:0] add,
                        input logic [63:0] data, input int stall, input string tag);
    bit          e;
    bit          known;
    logic [63:0] ev;
    logic [63:0] held;
    e     = pred_err(r, w, add);
    ev    = 64'd0;
    known = 1'b1;
    if (!e && r) begin
      for (int k = 0; k < 8; k++) begin
        if (!kn[int'(add) + k]) known = 1'b0;
        ev[8*k +: 8] = mdl[int'(add) + k];
      end
    end
    bus.req_valid  = 1'b1;
    bus.mem_r      = r;
    bus.mem_w      = w;
    bus.mem_add    = add;
    bus.mem_data   = data;
    bus.resp_ready = (stall == 0);
    check({tag, " req_ready idle"}, 64'(bus.req_ready), 64'd1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.mem_r     = 1'($urandom);
    bus.mem_w     = 1'($urandom);
    bus.mem_add   = {$urandom, $urandom};
    bus.mem_data  = {$urandom, $urandom};
    check({tag, " resp_valid access"}, 64'(bus.resp_valid), 64'd0);
    check({tag, " req_ready access"}, 64'(bus.req_ready), 64'd0);
    @(negedge clk);
    check({tag, " resp_valid"}, 64'(bus.resp_valid), 64'd1);
    check({tag, " dmem_error"}, 64'(bus.dmem_error), 64'(e));
    if (known) check({tag, " valM"}, bus.valM, ev);
    held = known ? ev : bus.valM;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check({tag, " bp resp_valid"}, 64'(bus.resp_valid), 64'd1);
      check({tag, " bp valM"}, bus.valM, held);
      check({tag, " bp req_ready"}, 64'(bus.req_ready), 64'd0);
    end
    bus.resp_ready = 1'b1;
    @(negedge clk);
    check({tag, " idle req_ready"}, 64'(bus.req_ready), 64'd1);
    check({tag, " idle resp_valid"}, 64'(bus.resp_valid), 64'd0);
    check({tag, " idle valM"}, bus.valM, 64'd0);
    check({tag, " idle dmem_error"}, 64'(bus.dmem_error), 64'd0);
    if (!e && w) begin
      for (int k = 0; k < 8; k++) begin
        mdl[int'(add) + k] = data[8*k +: 8];
        kn[int'(add) + k]  = 1'b1;
      end
    end
  endtask

  initial begin
    logic [63:0] a;
    logic        r;
    logic        w;
    int          op;
    int          sel;
    checks = 0;
    errors = 0;
    rst            = 1'b1;
    bus.req_valid  = 1'b0;
    bus.mem_r      = 1'b0;
    bus.mem_w      = 1'b0;
    bus.mem_add    = 64'd0;
    bus.mem_data   = 64'd0;
    bus.resp_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("reset req_ready", 64'(bus.req_ready), 64'd1);
    check("reset resp_valid", 64'(bus.resp_valid), 64'd0);
    check("reset valM", bus.valM, 64'd0);
    check("reset dmem_error", 64'(bus.dmem_error), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    access(1'b0, 1'b1, 64'h100, 64'h1122334455667788, 0, "wr100");
    access(1'b1, 1'b0, 64'h100, 64'd0, 0, "rd100");
    check("mem100 byte0", 64'(mdl[12'h100]), 64'h88);

    access(1'b1, 1'b0, 64'hFF9, 64'd0, 0, "rdFF9");
    access(1'b0, 1'b1, 64'hFF8, 64'hCAFEF00DDEADBEEF, 0, "wrFF8");
    access(1'b1, 1'b0, 64'hFF8, 64'd0, 0, "rdFF8");
    access(1'b0, 1'b1, 64'h0, 64'h0123456789ABCDEF, 0, "wr0");
    access(1'b0, 1'b1, 64'h1000, 64'hFFFFFFFFFFFFFFFF, 0, "wr1000");
    access(1'b1, 1'b0, 64'h0, 64'd0, 0, "rd0 after wr1000");
    access(1'b0, 1'b1, 64'h8000000000000100, 64'h5555AAAA5555AAAA, 0, "wr hi bits");
    access(1'b1, 1'b0, 64'h100, 64'd0, 0, "rd100 after hi");

    access(1'b1, 1'b0, 64'h100, 64'd0, 5, "bp");

    access(1'b0, 1'b1, 64'h200, 64'hA5A5A5A55A5A5A5A, 0, "wr200");
    access(1'b1, 1'b1, 64'h200, 64'h1111111111111111, 0, "rw200");
    access(1'b0, 1'b0, 64'h200, 64'h2222222222222222, 0, "nop200");
    access(1'b1, 1'b0, 64'h200, 64'd0, 0, "rd200");

    access(1'b0, 1'b1, 64'h300, 64'h0F0E0D0C0B0A0908, 0, "wr300");
    bus.req_valid = 1'b1;
    bus.mem_r     = 1'b0;
    bus.mem_w     = 1'b1;
    bus.mem_add   = 64'h300;
    bus.mem_data  = 64'hFFEEDDCCBBAA9988;
    @(negedge clk);
    bus.req_valid = 1'b0;
    rst           = 1'b1;
    @(negedge clk);
    check("rst req_ready", 64'(bus.req_ready), 64'd1);
    check("rst resp_valid", 64'(bus.resp_valid), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post rst resp_valid", 64'(bus.resp_valid), 64'd0);
    check("post rst req_ready", 64'(bus.req_ready), 64'd1);
    access(1'b1, 1'b0, 64'h300, 64'd0, 0, "rd300 after rst");

    access(1'b0, 1'b1, 64'h101, 64'h8877665544332211, 0, "wr101");
    access(1'b1, 1'b0, 64'h101, 64'd0, 0, "rd101");

    for (int i = 0; i < 40; i++) begin
      op  = int'($urandom_range(0, 9));
      sel = int'($urandom_range(0, 7));
      if (op < 5) begin
        r = 1'b0; w = 1'b1;
      end else if (op < 9) begin
        r = 1'b1; w = 1'b0;
      end else begin
        r = 1'($urandom); w = r;
      end
      if (sel == 0) a = {$urandom, $urandom};
      else if (sel == 1) a = 64'(MEM_BYTES - 8 + int'($urandom_range(0, 16)));
      else a = 64'(32'h400 + $urandom_range(0, 63));
      access(r, w, a, {$urandom, $urandom}, int'($urandom_range(0, 2)), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
